// File: rtl/a51_reverse_step.sv
`default_nettype none
// ============================================================================
// a51_reverse_step : enumerates the 0..4 A5/1 predecessors of a 64-bit state
// Revision: 1.0
// ============================================================================
module a51_reverse_step #(
  parameter int STATE_WIDTH = 64,   // only 19+22+23 is meaningful
  parameter bit EMIT_NONE   = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [STATE_WIDTH-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [STATE_WIDTH-1:0] out_state,
  output logic [1:0]             out_pattern,
  output logic                   out_last,
  output logic                   out_none,
  output logic [2:0]             out_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [STATE_WIDTH-1:0] cap_q;
  logic [STATE_WIDTH-1:0] cand_q [4];
  logic [3:0]             mask_q;
  logic [2:0]             count_q;
  logic                   none_q;

  logic [18:0]            r1;
  logic [21:0]            r2;
  logic [22:0]            r3;
  logic [18:0]            r1_un;
  logic [21:0]            r2_un;
  logic [22:0]            r3_un;
  logic [STATE_WIDTH-1:0] cand_w [4];
  logic [3:0]             mask_w;
  logic [2:0]             count_w;
  logic [1:0]             sel;
  logic [3:0]             low_bit;
  logic                   single;

  assign r1 = cap_q[18:0];
  assign r2 = cap_q[40:19];
  assign r3 = cap_q[63:41];

  // Undo the shift; the top bit is recovered from the feedback equation.
  assign r1_un = {r1[0] ^ r1[14] ^ r1[17] ^ r1[18], r1[18:1]};
  assign r2_un = {r2[0] ^ r2[21], r2[21:1]};
  assign r3_un = {r3[0] ^ r3[8] ^ r3[21] ^ r3[22], r3[22:1]};

  for (genvar p = 0; p < 4; p++) begin : g_pat
    localparam bit CLK1 = (p != 3);
    localparam bit CLK2 = (p != 2);
    localparam bit CLK3 = (p != 1);

    logic [18:0] p1;
    logic [21:0] p2;
    logic [22:0] p3;
    logic        k1;
    logic        k2;
    logic        k3;
    logic        maj;

    assign p1  = CLK1 ? r1_un : r1;
    assign p2  = CLK2 ? r2_un : r2;
    assign p3  = CLK3 ? r3_un : r3;
    assign k1  = p1[8];
    assign k2  = p2[10];
    assign k3  = p3[10];
    assign maj = (k1 & k2) | (k1 & k3) | (k2 & k3);

    // A register clocks exactly when its clock bit agrees with the majority.
    assign mask_w[p] = ((k1 == maj) == CLK1) &&
                       ((k2 == maj) == CLK2) &&
                       ((k3 == maj) == CLK3);
    assign cand_w[p] = {p3, p2, p1};
  end

  assign count_w = {2'b00, mask_w[0]} + {2'b00, mask_w[1]} +
                   {2'b00, mask_w[2]} + {2'b00, mask_w[3]};

  assign low_bit = mask_q & (~mask_q + 4'd1);
  assign single  = (mask_q & (mask_q - 4'd1)) == 4'd0;

  always_comb begin
    sel = 2'd0;
    casez (mask_q)
      4'b???1: sel = 2'd0;
      4'b??10: sel = 2'd1;
      4'b?100: sel = 2'd2;
      4'b1000: sel = 2'd3;
      default: sel = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_CALC;
      ST_CALC: state_d = ((mask_w != 4'd0) || EMIT_NONE) ? ST_EMIT : ST_IDLE;
      ST_EMIT: if (out_ready && out_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == ST_IDLE);
    out_valid   = 1'b0;
    out_state   = '0;
    out_pattern = 2'd0;
    out_last    = 1'b0;
    out_none    = 1'b0;
    out_count   = count_q;
    if (state_q == ST_EMIT) begin
      out_valid   = 1'b1;
      out_none    = none_q;
      out_last    = none_q | single;
      out_pattern = none_q ? 2'd0 : sel;
      out_state   = none_q ? cap_q : cand_q[sel];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cap_q   <= '0;
      mask_q  <= '0;
      count_q <= '0;
      none_q  <= 1'b0;
      for (int i = 0; i < 4; i++) cand_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (in_valid) cap_q <= in_state;
        ST_CALC: begin
          for (int i = 0; i < 4; i++) cand_q[i] <= cand_w[i];
          mask_q  <= mask_w;
          count_q <= count_w;
          none_q  <= (mask_w == 4'd0) && EMIT_NONE;
        end
        ST_EMIT: begin
          if (out_ready) begin
            mask_q <= mask_q & ~low_bit;
            if (out_last) none_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_a51_reverse_step.sv
`default_nettype none
// ============================================================================
// tb_a51_reverse_step : directed and random checks of the A5/1 reverse stepper
// Revision: 1.0
// ============================================================================
module tb_a51_reverse_step;

  localparam logic [63:0] ONES_PRED = 64'h7FFF_FEFF_FFFB_FFFF;
  localparam logic [63:0] FOUR_IN   = 64'h0008_0000_2000_0100;
  localparam logic [63:0] FOUR_P0   = 64'h0004_0000_1000_0080;
  localparam logic [63:0] FOUR_P1   = 64'h0008_0000_1000_0080;
  localparam logic [63:0] FOUR_P2   = 64'h0004_0000_2000_0080;
  localparam logic [63:0] FOUR_P3   = 64'h0004_0000_1000_0100;
  localparam logic [63:0] NONE_IN   = 64'h0010_0000_0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_last, out_none;
  logic [63:0] in_state, out_state;
  logic [1:0]  out_pattern;
  logic [2:0]  out_count;

  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b, out_none_b;
  logic [63:0] in_state_b, out_state_b;
  logic [1:0]  out_pattern_b;
  logic [2:0]  out_count_b;

  int total = 0;
  int bad   = 0;

  logic [63:0] bs [8];
  logic [1:0]  bp [8];
  logic        bl [8];
  logic        bn [8];
  logic [2:0]  bc [8];
  int          n_beats;
  int          first_valid;
  logic        timed_out;
  logic        ready_after;

  a51_reverse_step #(.STATE_WIDTH(64), .EMIT_NONE(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .out_pattern(out_pattern), .out_last(out_last), .out_none(out_none),
    .out_count(out_count)
  );

  a51_reverse_step #(.STATE_WIDTH(64), .EMIT_NONE(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_state(in_state_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_state(out_state_b),
    .out_pattern(out_pattern_b), .out_last(out_last_b), .out_none(out_none_b),
    .out_count(out_count_b)
  );

  // Forward majority-clocked step with the clocking pattern forced.
  function automatic logic [63:0] fwd(input logic [63:0] s, input logic [1:0] p);
    logic [18:0] a;
    logic [21:0] b;
    logic [22:0] c;
    a = s[18:0];
    b = s[40:19];
    c = s[63:41];
    if (p != 2'd3) a = {a[17:0], a[13] ^ a[16] ^ a[17] ^ a[18]};
    if (p != 2'd2) b = {b[20:0], b[20] ^ b[21]};
    if (p != 2'd1) c = {c[21:0], c[7] ^ c[20] ^ c[21] ^ c[22]};
    return {c, b, a};
  endfunction

  // Predecessor clock bits sit one below (shifted) or at (held) the current bits.
  function automatic logic [3:0] ref_mask(input logic [63:0] s);
    logic a1, a2, a3, b1, b2, b3;
    logic [3:0] m;
    a1 = s[9];  b1 = s[8];
    a2 = s[30]; b2 = s[29];
    a3 = s[52]; b3 = s[51];
    m[0] = (a1 == a2) && (a2 == a3);
    m[1] = (a1 == a2) && (b3 != a1);
    m[2] = (a1 == a3) && (b2 != a1);
    m[3] = (a2 == a3) && (b1 != a2);
    return m;
  endfunction

  task automatic collect(input logic [63:0] s);
    n_beats     = 0;
    first_valid = -1;
    timed_out   = 1'b1;
    ready_after = 1'b0;
    out_ready   = 1'b1;
    @(negedge clk);
    in_state = s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 32; cyc++) begin
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid) begin
        if (n_beats < 8) begin
          bs[n_beats] = out_state;
          bp[n_beats] = out_pattern;
          bl[n_beats] = out_last;
          bn[n_beats] = out_none;
          bc[n_beats] = out_count;
        end
        n_beats++;
        if (out_last) begin
          @(negedge clk);
          ready_after = in_ready;
          timed_out   = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if ({out_last, out_none, out_pattern, out_count} !== 7'd0) begin
      bad++; $display("FAIL reset_flags got=%b want=0", {out_last, out_none, out_pattern, out_count});
    end
    total++; if (out_state !== 64'd0) begin bad++; $display("FAIL reset_out_state got=%h want=0", out_state); end
  endtask

  task automatic test_zero();
    collect(64'd0);
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL zero_timeout got=%b want=0", timed_out); end
    total++; if (first_valid !== 1) begin bad++; $display("FAIL zero_latency got=%0d want=1", first_valid); end
    total++; if (n_beats !== 1) begin bad++; $display("FAIL zero_beats got=%0d want=1", n_beats); end
    total++; if (bs[0] !== 64'd0) begin bad++; $display("FAIL zero_state got=%h want=0", bs[0]); end
    total++; if ({bp[0], bl[0], bn[0], bc[0]} !== {2'd0, 1'b1, 1'b0, 3'd1}) begin
      bad++; $display("FAIL zero_fields got=%b want=%b", {bp[0], bl[0], bn[0], bc[0]}, {2'd0, 1'b1, 1'b0, 3'd1});
    end
    total++; if (ready_after !== 1'b1) begin bad++; $display("FAIL zero_ready_after got=%b want=1", ready_after); end
  endtask

  task automatic test_ones();
    collect(64'hFFFF_FFFF_FFFF_FFFF);
    total++; if (n_beats !== 1 || timed_out) begin bad++; $display("FAIL ones_beats got=%0d want=1", n_beats); end
    total++; if (bs[0] !== ONES_PRED) begin bad++; $display("FAIL ones_state got=%h want=%h", bs[0], ONES_PRED); end
    total++; if ({bp[0], bl[0], bc[0]} !== {2'd0, 1'b1, 3'd1}) begin
      bad++; $display("FAIL ones_fields got=%b want=%b", {bp[0], bl[0], bc[0]}, {2'd0, 1'b1, 3'd1});
    end
  endtask

  task automatic test_four();
    logic [63:0] exp_s [4];
    exp_s = '{FOUR_P0, FOUR_P1, FOUR_P2, FOUR_P3};
    collect(FOUR_IN);
    total++; if (n_beats !== 4 || timed_out) begin bad++; $display("FAIL four_beats got=%0d want=4", n_beats); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bs[i] !== exp_s[i] || bp[i] !== 2'(i) || bl[i] !== (i == 3) || bc[i] !== 3'd4) begin
        bad++;
        $display("FAIL four_beat%0d got=%h/%0d/%b/%0d want=%h/%0d/%b/4", i, bs[i], bp[i], bl[i], bc[i], exp_s[i], i, (i == 3));
      end
    end
  endtask

  task automatic test_none();
    collect(NONE_IN);
    total++; if (n_beats !== 1 || timed_out) begin bad++; $display("FAIL none_beats got=%0d want=1", n_beats); end
    total++; if ({bs[0], bp[0], bl[0], bn[0], bc[0]} !== {NONE_IN, 2'd0, 1'b1, 1'b1, 3'd0}) begin
      bad++; $display("FAIL none_fields got=%h/%0d/%b/%b/%0d want=%h/0/1/1/0", bs[0], bp[0], bl[0], bn[0], bc[0], NONE_IN);
    end
    // Without none-beats: load a count of 4 first so the later 0 is observable.
    @(negedge clk);
    in_state_b = FOUR_IN;
    in_valid_b = 1'b1;
    @(negedge clk);
    in_valid_b = 1'b0;
    repeat (8) @(negedge clk);
    total++; if (out_count_b !== 3'd4) begin bad++; $display("FAIL nonone_pre_count got=%0d want=4", out_count_b); end
    in_state_b = NONE_IN;
    in_valid_b = 1'b1;
    @(negedge clk);
    in_valid_b = 1'b0;
    total++; if ({in_ready_b, out_valid_b} !== 2'b00) begin
      bad++; $display("FAIL nonone_calc got=%b want=00", {in_ready_b, out_valid_b});
    end
    @(negedge clk);
    total++; if ({in_ready_b, out_valid_b, out_count_b} !== {1'b1, 1'b0, 3'd0}) begin
      bad++; $display("FAIL nonone_back got=%b want=10000", {in_ready_b, out_valid_b, out_count_b});
    end
  endtask

  task automatic test_random();
    logic [63:0] s;
    logic [3:0]  m;
    logic [3:0]  obs;
    int          exp_beats;
    logic        order_ok;
    for (int t = 0; t < 3000; t++) begin
      s = {$urandom(), $urandom()};
      if (t == 0) s = NONE_IN ^ 64'hFF00_0000_0000_00FF;
      m = ref_mask(s);
      exp_beats = (m == 4'd0) ? 1 : $countones(m);
      collect(s);
      total++;
      if (timed_out || n_beats !== exp_beats) begin
        bad++; $display("FAIL rand_beats t=%0d got=%0d want=%0d", t, n_beats, exp_beats);
      end
      obs = 4'd0;
      order_ok = 1'b1;
      for (int i = 0; i < n_beats && i < 8; i++) begin
        if (!bn[i]) begin
          obs[bp[i]] = 1'b1;
          total++;
          if (fwd(bs[i], bp[i]) !== s) begin
            bad++; $display("FAIL rand_fwd t=%0d beat=%0d got=%h want=%h", t, i, fwd(bs[i], bp[i]), s);
          end
        end
        if (i > 0 && bp[i] <= bp[i-1]) order_ok = 1'b0;
        if (bl[i] !== (i == n_beats - 1)) order_ok = 1'b0;
      end
      total++; if (obs !== m) begin bad++; $display("FAIL rand_mask t=%0d got=%b want=%b", t, obs, m); end
      total++; if (bc[0] !== 3'($countones(m))) begin
        bad++; $display("FAIL rand_count t=%0d got=%0d want=%0d", t, bc[0], $countones(m));
      end
      total++; if (order_ok !== 1'b1) begin bad++; $display("FAIL rand_order t=%0d got=0 want=1", t); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_s [4];
    logic [63:0] h_s;
    logic [1:0]  h_p;
    logic        h_l, h_n;
    logic [2:0]  h_c;
    logic        held, done, rdy;
    int          n;
    exp_s = '{FOUR_P0, FOUR_P1, FOUR_P2, FOUR_P3};
    n = 0; held = 1'b0; done = 1'b0;
    h_s = '0; h_p = '0; h_l = 1'b0; h_n = 1'b0; h_c = '0;
    out_ready = 1'b0;
    @(negedge clk);
    in_state = FOUR_IN;
    in_valid = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      in_valid = (cyc < 3);
      in_state = ~FOUR_IN;
      if (held) begin
        total++;
        if ({out_valid, out_state, out_pattern, out_last, out_none, out_count} !== {1'b1, h_s, h_p, h_l, h_n, h_c}) begin
          bad++; $display("FAIL stall_hold cyc=%0d got=%h/%0d/%b want=%h/%0d/%b", cyc, out_state, out_pattern, out_last, h_s, h_p, h_l);
        end
      end
      rdy = (cyc == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      out_ready = rdy;
      held = 1'b0;
      if (out_valid) begin
        if (rdy) begin
          if (n < 8) begin bs[n] = out_state; bp[n] = out_pattern; bl[n] = out_last; bc[n] = out_count; end
          n++;
          if (out_last) done = 1'b1;
        end else begin
          held = 1'b1;
          h_s = out_state; h_p = out_pattern; h_l = out_last; h_n = out_none; h_c = out_count;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++; if (done !== 1'b1 || n !== 4) begin bad++; $display("FAIL stall_beats got=%0d want=4", n); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bs[i] !== exp_s[i] || bp[i] !== 2'(i) || bl[i] !== (i == 3) || bc[i] !== 3'd4) begin
        bad++; $display("FAIL stall_beat%0d got=%h/%0d/%b want=%h/%0d/%b", i, bs[i], bp[i], bl[i], exp_s[i], i, (i == 3));
      end
    end
    total++; if ({in_ready, out_valid} !== 2'b10) begin
      bad++; $display("FAIL stall_busy_input got=%b want=10", {in_ready, out_valid});
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    @(negedge clk);
    in_state = FOUR_IN;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b want=1", out_valid); end
    #2 reset_n = 1'b0;
    #1;
    total++; if ({in_ready, out_valid, out_last, out_none, out_count, out_pattern} !== {1'b1, 8'd0}) begin
      bad++; $display("FAIL midrst_flags got=%b want=100000000", {in_ready, out_valid, out_last, out_none, out_count, out_pattern});
    end
    total++; if (out_state !== 64'd0) begin bad++; $display("FAIL midrst_state got=%h want=0", out_state); end
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if ({in_ready, out_valid} !== 2'b10) begin
      bad++; $display("FAIL midrst_after got=%b want=10", {in_ready, out_valid});
    end
    collect(64'd0);
    total++; if (n_beats !== 1 || timed_out || bs[0] !== 64'd0 || bc[0] !== 3'd1) begin
      bad++; $display("FAIL midrst_next got=%0d/%h/%0d want=1/0/1", n_beats, bs[0], bc[0]);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_state    = '0;
    out_ready   = 1'b1;
    in_valid_b  = 1'b0;
    in_state_b  = '0;
    out_ready_b = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    @(negedge clk);
    test_zero();
    test_ones();
    test_four();
    test_none();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
